mul_unit: RTL and testbench

- Iterative shift-add multiplier for SimpleCore.
- Produces a 2*WIDTH-bit product and the NZCV condition flags.
- Writes those flags into the status register through its flag-update interface: condFlag, write enable and select.
- Sits beside the ALU in the execute stage and is started by the controller with a one-cycle start pulse.

---
 rtl/mul_unit_if.sv | 28 ++
 rtl/mul_unit.sv | 142 ++++++++++++++
 tb/tb_mul_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_unit_if.sv
// Controller-side bundle for the iterative multiplier: operand request, status,
// product and the flag-update signals that feed the status register.
interface mul_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             flush;
  logic             signedOp;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] resLo;
  logic [WIDTH-1:0] resHi;
  logic [3:0]       condFlag;
  logic             flagWe;
  logic             flagSel;

  modport master (
    output start, flush, signedOp, opA, opB,
    input  busy, done, resLo, resHi, condFlag, flagWe, flagSel
  );

  modport slave (
    input  start, flush, signedOp, opA, opB,
    output busy, done, resLo, resHi, condFlag, flagWe, flagSel
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier: WIDTH add/shift cycles on operand magnitudes,
// one sign-fix cycle, then a one-cycle done/flag write into the status register.
module mul_unit #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      nreset,
  mul_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_signed;
  logic               r_neg;
  logic               r_busy;
  logic               r_done;
  logic               r_flag_we;
  logic               r_flag_sel;
  logic [WIDTH-1:0]   r_res_lo;
  logic [WIDTH-1:0]   r_res_hi;
  logic [3:0]         r_cond;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH-1:0]   w_hi;
  logic [3:0]         w_flags;

  // The most-negative value negates to itself, which read unsigned is exactly its magnitude.
  assign w_mag_a = (bus.signedOp && bus.opA[WIDTH-1]) ? -bus.opA : bus.opA;
  assign w_mag_b = (bus.signedOp && bus.opB[WIDTH-1]) ? -bus.opB : bus.opB;

  assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_lo   = w_prod[WIDTH-1:0];
  assign w_hi   = w_prod[2*WIDTH-1:WIDTH];

  // {N,Z,C,V}: C and V report whether the product overflowed the low half.
  assign w_flags = {
    w_lo[WIDTH-1],
    ~|w_lo,
    ~r_signed & (|w_hi),
    r_signed & (w_hi != {WIDTH{w_lo[WIDTH-1]}})
  };

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mcand    <= '0;
      r_acc      <= '0;
      r_mplier   <= '0;
      r_signed   <= 1'b0;
      r_neg      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_flag_we  <= 1'b0;
      r_flag_sel <= 1'b0;
      r_res_lo   <= '0;
      r_res_hi   <= '0;
      r_cond     <= 4'b0000;
    end else begin
      r_done     <= 1'b0;
      r_flag_we  <= 1'b0;
      r_flag_sel <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_signed <= bus.signedOp;
            r_neg    <= bus.signedOp & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == LAST_ITER) begin
              r_cnt   <= '0;
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_FIX: begin
          r_busy <= 1'b0;
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            r_res_lo   <= w_lo;
            r_res_hi   <= w_hi;
            r_cond     <= w_flags;
            r_done     <= 1'b1;
            r_flag_we  <= 1'b1;
            r_flag_sel <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.resLo    = r_res_lo;
  assign bus.resHi    = r_res_hi;
  assign bus.condFlag = r_cond;
  assign bus.flagWe   = r_flag_we;
  assign bus.flagSel  = r_flag_sel;
endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: issued operations push expected results from an
// arithmetic model; a negedge monitor pops and compares on every done pulse.
module tb_mul_unit;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [3:0]   fl;
    int           cyc;
  } exp_t;

  logic clk;
  logic nreset;
  int   cyc;
  int   n_pass;
  int   n_total;
  exp_t sb[$];
  exp_t last_done;

  mul_unit_if #(.WIDTH(W)) bus ();

  mul_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain integer product of the interpreted operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int dc);
    longint      pa, pb, p;
    logic [63:0] pw;
    exp_t        e;
    pa = longint'(a);
    pb = longint'(b);
    if (s && a[W-1]) pa -= 65536;
    if (s && b[W-1]) pb -= 65536;
    p    = pa * pb;
    pw   = p;
    e.lo = pw[15:0];
    e.hi = pw[31:16];
    e.fl = {pw[15], pw[15:0] == 16'h0, !s && (p > 65535), s && (p < -32768 || p > 32767)};
    e.cyc = dc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (nreset) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("txn cycle %0d: resHi=0x%04h resLo=0x%04h condFlag=%b", cyc,
                   bus.resHi, bus.resLo, bus.condFlag);
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("resLo", 32'(bus.resLo), 32'(e.lo));
          chk("resHi", 32'(bus.resHi), 32'(e.hi));
          chk("condFlag", 32'(bus.condFlag), 32'(e.fl));
          chk("flagWe_on_done", 32'(bus.flagWe), 32'd1);
          chk("flagSel_on_done", 32'(bus.flagSel), 32'd1);
          chk("busy_in_done", 32'(bus.busy), 32'd0);
          last_done = e;
        end
      end else begin
        chk("flagWe_idle", 32'({bus.flagWe, bus.flagSel}), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.opA      = a;
    bus.opB      = b;
    bus.signedOp = s;
    bus.start    = 1'b1;
    sb.push_back(model(a, b, s, cyc + W + 2));
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() > 0 && k < 100) begin
      tick();
      k++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    issue(a, b, s);
    wait_drain();
  endtask

  initial begin
    int c;
    logic [31:0] rnd;
    n_pass  = 0;
    n_total = 0;
    nreset  = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.signedOp = 1'b0;
    bus.opA = '0;
    bus.opB = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_flags_we_sel", 32'({bus.flagWe, bus.flagSel}), 32'd0);
    chk("rst_res", {bus.resHi, bus.resLo}, 32'd0);
    chk("rst_cond", 32'(bus.condFlag), 32'd0);
    nreset = 1'b1;
    tick();

    // Directed cases, including overflow and most-negative operands.
    run_op(16'd3, 16'd5, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0);
    run_op(16'h1234, 16'h0000, 1'b0);
    run_op(16'hFFFD, 16'h0005, 1'b1);
    run_op(16'h4000, 16'h0004, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b1);
    run_op(16'h0000, 16'h8000, 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      rnd = $urandom();
      a = rnd[15:0];
      b = rnd[31:16];
      run_op(a, b, 1'($urandom_range(0, 1)));
    end

    // Starts during an operation and in its DONE cycle are dropped; the next cycle is accepted.
    c = cyc;
    issue(16'd100, 16'd200, 1'b0);
    while (cyc < c + 3) tick();
    bus.opA = 16'h7777; bus.opB = 16'h1111; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (cyc < c + 18) tick();
    bus.opA = 16'h5555; bus.opB = 16'h2222; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    issue(16'hFFF0, 16'h0003, 1'b1);
    wait_drain();

    // Flush mid-calculation: no completion, previous outputs retained.
    c = cyc;
    bus.opA = 16'd7; bus.opB = 16'd7; bus.signedOp = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (cyc < c + 10) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy_low", 32'(bus.busy), 32'd0);
    repeat (40) tick();
    chk("flush_resLo_kept", 32'(bus.resLo), 32'(last_done.lo));
    chk("flush_resHi_kept", 32'(bus.resHi), 32'(last_done.hi));
    chk("flush_cond_kept", 32'(bus.condFlag), 32'(last_done.fl));

    // flush together with start in IDLE suppresses the start.
    bus.flush = 1'b1; bus.start = 1'b1;
    tick();
    bus.flush = 1'b0; bus.start = 1'b0;
    chk("flush_start_idle_busy", 32'(bus.busy), 32'd0);
    repeat (25) tick();

    // Asynchronous reset in the middle of a cycle during CALC.
    c = cyc;
    issue(16'h0123, 16'h0456, 1'b0);
    while (cyc < c + 6) tick();
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    #3;
    nreset = 1'b0;
    #1;
    sb.delete();
    chk("areset_busy", 32'(bus.busy), 32'd0);
    chk("areset_done_we", 32'({bus.done, bus.flagWe}), 32'd0);
    chk("areset_cond", 32'(bus.condFlag), 32'd0);
    chk("areset_res", {bus.resHi, bus.resLo}, 32'd0);
    #3;
    nreset = 1'b1;
    tick();
    run_op(16'd2, 16'd2, 1'b0);
    chk("post_reset_resLo", 32'(bus.resLo), 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
